// File: rtl/uart_rx_if.sv
// Byte handshake between the UART receiver (master) and its consumer (slave).
interface uart_rx_if;
   logic [7:0] rx_data;
   logic       rx_data_valid;
   logic       rx_data_ready;
   logic       rx_frame_err;
   logic       rx_overrun;

   modport master (
      output rx_data,
      output rx_data_valid,
      output rx_frame_err,
      output rx_overrun,
      input  rx_data_ready
   );

   modport slave (
      input  rx_data,
      input  rx_data_valid,
      input  rx_frame_err,
      input  rx_overrun,
      output rx_data_ready
   );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver with mid-bit sampling and a one-entry holding register.
// Define UART_RX_MAJORITY_EN for 2-of-3 majority sampling around mid-bit.
module uart_rx #(
   parameter int unsigned CLK_FRE   = 50,
   parameter int unsigned BAUD_RATE = 9600
) (
   input  logic      clk,
   input  logic      rst_n,
   input  logic      rx_pin,
   uart_rx_if.master rx_bus
);
   localparam int unsigned CYCLE = CLK_FRE * 1000000 / BAUD_RATE;
   localparam int unsigned HALF  = CYCLE / 2;
`ifdef UART_RX_MAJORITY_EN
   localparam logic [15:0] SMP_PT = 16'(HALF);
`else
   localparam logic [15:0] SMP_PT = 16'(HALF - 1);
`endif
   localparam logic [15:0] BIT_END = 16'(CYCLE - 1);

   typedef enum logic [1:0] {StIdle, StStart, StRecByte, StStop} state_e;

   state_e      state_q, state_d;
   logic        s0, s1, s2;
   logic        fall, sample_val;
   logic [15:0] cycle_cnt;
   logic [2:0]  bit_cnt;
   logic [7:0]  shift_reg;
   logic [7:0]  data_q;
   logic        valid_q, ferr_q, ovr_q;
   logic        at_smp, at_end;
   logic        shift_en, bit_inc, load, ferr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s0 <= 1'b1;
         s1 <= 1'b1;
         s2 <= 1'b1;
      end else begin
         s0 <= rx_pin;
         s1 <= s0;
         s2 <= s1;
      end
   end

   assign fall   = s2 & ~s1;
   assign at_smp = (cycle_cnt == SMP_PT);
   assign at_end = (cycle_cnt == BIT_END);

`ifdef UART_RX_MAJORITY_EN
   // Two early samples are held; the third is s1 itself at the decision point.
   logic [1:0] maj_q;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         maj_q <= 2'b11;
      end else begin
         if (cycle_cnt == SMP_PT - 16'd2) maj_q[0] <= s1;
         if (cycle_cnt == SMP_PT - 16'd1) maj_q[1] <= s1;
      end
   end
   assign sample_val = (maj_q[0] & maj_q[1]) | (maj_q[0] & s1) | (maj_q[1] & s1);
`else
   assign sample_val = s1;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= StIdle;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:    if (fall) state_d = StStart;
         StStart: begin
            if (at_smp && sample_val) state_d = StIdle;
            else if (at_end)          state_d = StRecByte;
         end
         StRecByte: if (at_end && bit_cnt == 3'd7) state_d = StStop;
         StStop:    if (at_smp) state_d = StIdle;
         default:   state_d = StIdle;
      endcase
   end

   always_comb begin
      shift_en = (state_q == StRecByte) && at_smp;
      bit_inc  = (state_q == StRecByte) && at_end;
      load     = (state_q == StStop) && at_smp && sample_val;
      ferr     = (state_q == StStop) && at_smp && !sample_val;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cycle_cnt <= '0;
         bit_cnt   <= '0;
         shift_reg <= '0;
      end else begin
         if (state_d != state_q || bit_inc) cycle_cnt <= '0;
         else                               cycle_cnt <= cycle_cnt + 16'd1;
         if (state_q != StRecByte) bit_cnt <= '0;
         else if (bit_inc)         bit_cnt <= bit_cnt + 3'd1;
         if (shift_en) shift_reg[bit_cnt] <= sample_val;
      end
   end

   // The receiver never waits on the consumer: a new byte always lands.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_q  <= '0;
         valid_q <= 1'b0;
         ferr_q  <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         ferr_q <= ferr;
         ovr_q  <= load && valid_q && !rx_bus.rx_data_ready;
         if (load) begin
            data_q  <= shift_reg;
            valid_q <= 1'b1;
         end else if (valid_q && rx_bus.rx_data_ready) begin
            valid_q <= 1'b0;
         end
      end
   end

   assign rx_bus.rx_data       = data_q;
   assign rx_bus.rx_data_valid = valid_q;
   assign rx_bus.rx_frame_err  = ferr_q;
   assign rx_bus.rx_overrun    = ovr_q;
endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx at CYCLE=16; a negedge monitor checks every accepted byte.
module tb_uart_rx;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic rx_pin = 1'b1;
   logic ready = 1'b0;

   int checks = 0;
   int failures = 0;
   int n_acc = 0;
   int n_ferr = 0;
   int n_ovr = 0;
   logic [7:0] exp_q[$];

   uart_rx_if bus ();
   assign bus.rx_data_ready = ready;

   uart_rx #(.CLK_FRE(1), .BAUD_RATE(62500)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .rx_pin (rx_pin),
      .rx_bus (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Inputs change 1 time unit after the rising edge.
   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send_bit(input logic v, input logic glitch);
      for (int j = 0; j < 16; j++) begin
         rx_pin = (glitch && j == 7) ? ~v : v;
         tick(1);
      end
   endtask

   task automatic send_frame(input logic [7:0] b, input logic stop, input int gbit);
      send_bit(1'b0, 1'b0);
      for (int i = 0; i < 8; i++) send_bit(b[i], gbit == i);
      send_bit(stop, 1'b0);
      rx_pin = 1'b1;
   endtask

   // Monitor: pops on acceptance, checks stability, pulse widths and valid drop.
   logic       prev_v, prev_r, prev_e, prev_o;
   logic [7:0] prev_d;
   always @(negedge clk) begin
      if (!rst_n) begin
         prev_v = 1'b0; prev_r = 1'b0; prev_e = 1'b0; prev_o = 1'b0; prev_d = '0;
      end else begin
         if (prev_v && !prev_r)
            check("hold_stable", {bus.rx_data_valid, (bus.rx_data == prev_d) | bus.rx_overrun},
                  2'b11);
         if (prev_v && prev_r) check("valid_drop", bus.rx_data_valid, 1'b0);
         if (prev_e) check("ferr_width", bus.rx_frame_err, 1'b0);
         if (prev_o) check("ovr_width", bus.rx_overrun, 1'b0);
         if (bus.rx_frame_err) n_ferr++;
         if (bus.rx_overrun) n_ovr++;
         if (bus.rx_data_valid && ready) begin
            n_acc++;
            if (exp_q.size() == 0) check("unexpected_byte", bus.rx_data, 32'hffff_ffff);
            else check("rx_data", bus.rx_data, exp_q.pop_front());
         end
         prev_v = bus.rx_data_valid; prev_r = ready; prev_d = bus.rx_data;
         prev_e = bus.rx_frame_err;  prev_o = bus.rx_overrun;
      end
   end

   int a0, e0, o0;
   initial begin
      tick(3);
      @(negedge clk);
      check("rst_outputs", {bus.rx_data, bus.rx_data_valid, bus.rx_frame_err, bus.rx_overrun},
            '0);
      tick(1);
      rst_n = 1'b1;
      tick(20);

      // 0x55 with ready held high
      ready = 1'b1;
      a0 = n_acc; e0 = n_ferr; o0 = n_ovr;
      exp_q.push_back(8'h55);
      send_frame(8'h55, 1'b1, -1);
      tick(20);
      check("t1_acc", n_acc - a0, 1);
      check("t1_ferr", n_ferr - e0, 0);
      check("t1_ovr", n_ovr - o0, 0);

      // 0xA3 held 100 clocks before acceptance
      ready = 1'b0;
      exp_q.push_back(8'hA3);
      send_frame(8'hA3, 1'b1, -1);
      tick(100);
      @(negedge clk);
      check("t2_held", {bus.rx_data_valid, bus.rx_data}, {1'b1, 8'hA3});
      tick(1);
      ready = 1'b1;
      tick(1);
      @(negedge clk);
      check("t2_drop", bus.rx_data_valid, 1'b0);

      // back-to-back with no consumer: second byte overwrites
      tick(1);
      ready = 1'b0;
      a0 = n_acc; o0 = n_ovr;
      send_frame(8'h12, 1'b1, -1);
      send_frame(8'h34, 1'b1, -1);
      tick(20);
      @(negedge clk);
      check("t3_data", {bus.rx_data_valid, bus.rx_data}, {1'b1, 8'h34});
      check("t3_ovr", n_ovr - o0, 1);
      exp_q.push_back(8'h34);
      tick(1);
      ready = 1'b1;
      tick(4);
      check("t3_acc", n_acc - a0, 1);

      // framing error, then recovery
      a0 = n_acc; e0 = n_ferr;
      send_frame(8'h7E, 1'b0, -1);
      tick(16);
      check("t4_ferr", n_ferr - e0, 1);
      check("t4_noacc", n_acc - a0, 0);
      exp_q.push_back(8'h81);
      send_frame(8'h81, 1'b1, -1);
      tick(20);
      check("t4_acc", n_acc - a0, 1);

      // short low glitch on the idle line
      a0 = n_acc; e0 = n_ferr;
      rx_pin = 1'b0;
      tick(3);
      rx_pin = 1'b1;
      tick(200);
      check("t5_glitch", {n_acc - a0, n_ferr - e0}, '0);
`ifdef UART_RX_MAJORITY_EN
      exp_q.push_back(8'h00);
      send_frame(8'h00, 1'b1, 3);
      tick(20);
      check("t5_major", n_acc - a0, 1);
      a0 = n_acc;
`endif

      // reset during bit 4 of 0xFF
      send_bit(1'b0, 1'b0);
      for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b0);
      tick(8);
      rst_n = 1'b0;
      tick(2);
      @(negedge clk);
      check("t6_rst_valid", bus.rx_data_valid, 1'b0);
      tick(1);
      rst_n = 1'b1;
      tick(100);
      check("t6_noacc", n_acc - a0, 0);
      exp_q.push_back(8'h3C);
      send_frame(8'h3C, 1'b1, -1);
      tick(20);
      check("t6_acc", n_acc - a0, 1);
      check("sb_empty", exp_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
